// File: rtl/design_37_pkg.sv
// design_37_pkg: shared state encoding and default operand width for design_37.
`default_nettype none

package design_37_pkg;

  localparam int DEFAULT_W = 12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage : design_37_pkg

`default_nettype wire

// File: rtl/design_37_add.sv
// design_37_add: W-bit combinational adder returning the wrapped sum and carry-out.
`default_nettype none

module design_37_add #(
  parameter int W = design_37_pkg::DEFAULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule : design_37_add

`default_nettype wire

// File: rtl/design_37.sv
// design_37: registered adder; y/valid one cycle after start. Optional carry port
// appears when the DESIGN_37_CARRY_EN macro is defined.
`default_nettype none

module design_37
  import design_37_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
`ifdef DESIGN_37_CARRY_EN
  output logic         carry,
`endif
  output logic         valid
);

  state_t         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  design_37_add #(
    .W (W)
  ) u_add (
    .a    (a),
    .b    (b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    case (state_q)
      IDLE:    state_d = start ? DONE : IDLE;
      DONE:    state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    // Operands are captured only on a start edge; otherwise y holds.
    if (start) y_d = add_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign y     = y_q;
  assign valid = (state_q == DONE);

`ifdef DESIGN_37_CARRY_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (start) carry_d = add_cout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry = add_cout;
`endif

endmodule : design_37

`default_nettype wire

// File: tb/tb_design_37.sv
// tb_design_37: directed self-checking bench for design_37 at W=12.
`default_nettype none

module tb_design_37;

  localparam int W = 12;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;
`ifdef DESIGN_37_CARRY_EN
  logic         carry;
`endif

  int n_total;
  int n_pass;

  design_37 #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
`ifdef DESIGN_37_CARRY_EN
    .carry (carry),
`endif
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got_y, input logic got_v,
                     input logic [W-1:0] exp_y, input logic exp_v);
    n_total++;
    if (got_y !== exp_y || got_v !== exp_v)
      $display("FAIL %s: y=%0d valid=%b, expected y=%0d valid=%b", name, got_y, got_v, exp_y, exp_v);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #2;
    chk("reset_async", y, valid, 12'd0, 1'b0);
    tick(); tick();
    chk("reset_held", y, valid, 12'd0, 1'b0);
    #3 rst = 1'b0;
    tick();
    chk("post_reset_idle", y, valid, 12'd0, 1'b0);
  endtask

  task automatic test_basic();
    start = 1'b1; a = 12'd100; b = 12'd200;
    tick();
    chk("basic_result", y, valid, 12'd300, 1'b1);
    start = 1'b0; a = 12'd7; b = 12'd9;
    tick();
    chk("basic_pulse_end", y, valid, 12'd300, 1'b0);
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = b + 12'd123;
      tick();
      chk("idle_hold", y, valid, 12'd300, 1'b0);
    end
  endtask

  task automatic test_wrap();
    start = 1'b1; a = 12'd4095; b = 12'd1;
    tick();
    chk("wrap_result", y, valid, 12'd0, 1'b1);
`ifdef DESIGN_37_CARRY_EN
    n_total++;
    if (carry !== 1'b1) $display("FAIL wrap_carry: carry=%b, expected 1", carry);
    else n_pass++;
`endif
    start = 1'b1; a = 12'd1; b = 12'd2;
    tick();
    chk("no_wrap_result", y, valid, 12'd3, 1'b1);
`ifdef DESIGN_37_CARRY_EN
    n_total++;
    if (carry !== 1'b0) $display("FAIL no_wrap_carry: carry=%b, expected 0", carry);
    else n_pass++;
`endif
    start = 1'b0;
    tick();
    chk("wrap_pulse_end", y, valid, 12'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; a = 12'd10; b = 12'd20;
    tick();
    chk("b2b_first", y, valid, 12'd30, 1'b1);
    a = 12'd30; b = 12'd40;
    tick();
    chk("b2b_second", y, valid, 12'd70, 1'b1);
    start = 1'b0;
    tick();
    chk("b2b_end", y, valid, 12'd70, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; a = 12'd5; b = 12'd6;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_immediate", y, valid, 12'd0, 1'b0);
    tick();
    start = 1'b0;
    chk("rst_mid_held", y, valid, 12'd0, 1'b0);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_pulse", y, valid, 12'd0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, exp_sum;
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(1023));
      rb = W'($urandom_range(1023));
      exp_sum = ra + rb;
      start = 1'b1; a = ra; b = rb;
      tick();
      chk("rand_valid", y, valid, exp_sum, 1'b1);
      start = 1'b0; a = ~ra; b = ~rb;
      tick();
      chk("rand_gap1", y, valid, exp_sum, 1'b0);
      tick();
      chk("rand_gap2", y, valid, exp_sum, 1'b0);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    test_reset();
    test_basic();
    test_idle_hold();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_design_37

`default_nettype wire

// File: doc/design_37.md
DESIGN_37 -- requirements
Module: design_37

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL provide parameter: W, 12, operand/result width in bits (legal range 1..32).
REQ-003 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL provide port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL provide port: start  input  1  request; sample a and b on this edge.
REQ-006 SHALL provide port: a  input  W  first operand.
REQ-007 SHALL provide port: b  input  W  second operand.
REQ-008 SHALL provide port: y  output  W  registered sum result.
REQ-009 SHALL provide port: valid  output  1  result-valid strobe.
REQ-010 SHALL provide port, only when DESIGN_37_CARRY_EN is defined: carry  output  1  carry-out of the sum.

Function
REQ-011 SHALL sample a and b only on a rising clk edge where start=1; a and b are ignored on all other edges.
REQ-012 SHALL, on a start edge, load y with (a+b) mod 2^W, so results wrap and never saturate.
REQ-013 SHALL assert valid exactly on the cycle following each start cycle, with latency 1 clock.
REQ-014 SHALL drive valid low on any cycle not preceded by a start cycle, so an isolated start gives a 1-cycle pulse.
REQ-015 SHALL treat back-to-back or held start as follows: valid stays high every cycle after a start cycle, and y shows the newest sampled sum each cycle.
REQ-016 SHALL hold y unchanged while valid=0; y is only meaningful when valid=1.
REQ-017 SHALL keep the internal control to two states: IDLE (valid=0) and DONE (valid=1).
REQ-018 SHALL transition IDLE->DONE and DONE->DONE on start=1, and DONE->IDLE and IDLE->IDLE on start=0.
REQ-019 SHALL drive y and valid directly from flops, with no combinational input-to-output path.

Reset
REQ-020 SHALL, while rst=1, force y=0, valid=0, carry=0 and state=IDLE immediately and asynchronously.
REQ-021 SHALL discard any start sampled in the cycle before reset asserts, so no valid appears after reset.
REQ-022 SHALL ignore start on the first clk edge after rst deasserts only if that edge falls within the reset-recovery window; otherwise the first post-reset start is honoured normally.

Configuration
REQ-023 SHALL, with DESIGN_37_CARRY_EN defined, provide the carry port, registered alongside y on each start edge as bit W of the (W+1)-bit sum.
REQ-024 SHALL, with DESIGN_37_CARRY_EN undefined, omit the carry port and carry flop, and all other behaviour SHALL be identical.

Structure
REQ-025 SHALL place the state enum (IDLE, DONE) and the default width constant (12) in package design_37_pkg.
REQ-026 SHALL instantiate one combinational sub-module, design_37_add, as a W-bit adder producing sum[W-1:0] and carry-out.
REQ-027 SHALL keep all registers in design_37 top-level.

Verification (W=12)
REQ-028 SHALL cover: start=1 with a=100, b=200 for one cycle -> next cycle valid=1, y=300, and valid=0 on the cycle after.
REQ-029 SHALL cover: start with a=4095, b=1 -> y=0 and valid=1 next cycle; with DESIGN_37_CARRY_EN, carry=1.
REQ-030 SHALL cover: start on two consecutive cycles with (10,20) then (30,40) -> valid high for 2 cycles, y=30 then y=70.
REQ-031 SHALL cover: start with a=5, b=6, then rst=1 before the next edge -> valid=0 and y=0 immediately, with no valid pulse afterwards.
REQ-032 SHALL cover: idle for 5 cycles after a result of 300, with a and b toggling and start=0 -> y stays 300 and valid stays 0.
REQ-033 SHALL cover: 10 random starts with operands in 0..1023 spaced 3 cycles apart -> every valid pulse has y equal to the reference sum of the last start.
